wb_uart_lite: RTL and testbench
===============================

# wb_uart_lite

Parametrised Wishbone-slave UART with TX and RX FIFOs, configurable frame format, runtime-programmable bit divisor and internal loopback. Successor to the fixed 8-bit uart16550 slave. It sits on the 8-bit Wishbone bus in the same position as that slave (`stx_pad_o` / `srx_pad_i` to the pads). It is the block the UART UVC drives in the next bench generation.

## Interface
- FIFO_DEPTH, 16: entries per TX and RX FIFO. Must be a power of 2 and ≥2.
- DATA_BITS, 8: data bits per frame, 5..8.
- STOP_BITS, 1: stop bits transmitted, 1 or 2.
- DIV_RESET, 867: reset value of the divisor. Clocks per bit = DIV+1.
- wb_clk_i  in  1  single clock; all logic on its rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wb_adr_i  in  3  register address.
- wb_dat_i  in  8  write data.
- wb_dat_o  out  8  read data, valid while wb_ack_o=1.
- wb_we_i  in  1  1 = write.
- wb_cyc_i, wb_stb_i  in  1 each  Wishbone classic cycle/strobe.
- wb_ack_o  out  1  single-cycle acknowledge.
- stx_pad_o  out  1  serial TX, idle high.
- srx_pad_i  in  1  serial RX, asynchronous to wb_clk_i.
- int_o  out  1  registered interrupt.

## Operation
- Registers, addressed by wb_adr_i:
  - 0 DATA:
    - Write pushes wb_dat_i[DATA_BITS-1:0] to the TX FIFO. If the FIFO is full, the data is dropped and TX_OVF is set.
    - Read pops the RX FIFO; data is zero-extended. If the FIFO is empty, the read returns 0x00 and does not pop.
  - 1 STATUS (R): bit0 RX_NE, bit1 TX_FULL, bit2 TX_IDLE (TX FIFO empty and shifter in IDLE), bit3 RX_OVR, bit4 FRM_ERR, bit5 TX_OVF. Bits 3-5 are sticky. Writing 1 to a bit clears it; a set on the same edge wins over the clear.
  - 2 DIV_LO, 3 DIV_HI: 16-bit divisor. DIV values <3 are treated as 3.
  - 4 CTRL: bit0 TX_EN, bit1 RX_EN, bit2 LOOP. Reset value 0x03.
  - Addresses 5-7: read 0x00, writes ignored.
- Wishbone bus:
  - wb_ack_o is asserted the cycle after cyc&stb&!ack, for exactly one cycle.
  - Register side effects (push, pop, clear) occur on the edge that asserts ack.
  - wb_dat_o is registered on that same edge and is 0 when ack is low.
- TX state machine, states IDLE → START → DATA → STOP → IDLE:
  - In IDLE, if TX_EN=1 and the FIFO is non-empty: pop, latch DIV, go to START.
  - START drives 0; DATA drives the bits LSB first; STOP drives 1.
  - Each bit lasts DIV+1 clocks. STOP lasts STOP_BITS×(DIV+1) clocks.
  - At the end of STOP, if data is pending, the next START begins with no idle gap.
  - Clearing TX_EN mid-frame completes the current frame only.
- RX path:
  - srx_pad_i passes through a 2-flop synchroniser. With LOOP=1 the RX input is stx_pad_o instead, and stx_pad_o is still driven.
  - The RX state machine runs IDLE → START → DATA → STOP and latches DIV at the detected falling edge.
  - START: sample at DIV>>1 clocks. If the sample is high, it is a false start; return to IDLE.
  - DATA: sample every DIV+1 clocks.
  - STOP: sample once.
    - Low: set FRM_ERR, discard the byte.
    - High with FIFO full: set RX_OVR, drop the byte.
    - High otherwise: push.
  - Return to IDLE right after the mid-stop sample.
  - RX_EN=0 holds RX in IDLE; a frame already in progress completes.
- FIFOs:
  - Simultaneous push and pop on the same edge both take effect and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.
- int_o, registered: RX_NE | RX_OVR | FRM_ERR | TX_OVF.
- Reset (asynchronous, any time, including mid-frame):
  - stx_pad_o=1; wb_ack_o=0; wb_dat_o=0; int_o=0.
  - FIFOs empty; sticky bits 0; both state machines in IDLE.
  - DIV=DIV_RESET; CTRL=0x03.

## Timing
- TX start latency: for a DATA write acked at edge E with TX idle, stx_pad_o falls after edge E+1.
- Frame length: (1+DATA_BITS+STOP_BITS)×(DIV+1) clocks.
- RX_NE rises one clock after the mid-stop sample edge.
- int_o lags its source bits by one clock.
- A new DIV value applies from the next frame start; a frame in progress is unaffected.

## Test plan
1. Reset defaults: assert reset → stx_pad_o=1, STATUS=0x04, CTRL=0x03, DIV_HI:LO=0x0363.
2. Single TX frame: DIV=3, write DATA=0xA5 → stx_pad_o low for 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high. Frame is 40 clocks; TX_IDLE=1 afterwards.
3. Loopback burst: LOOP=1, DIV=3, write 0x01..0x10 back-to-back → no gap between frames, 16 bytes read back in order, RX_OVR=0.
4. RX overrun: FIFO_DEPTH=16, 17 frames driven on srx_pad_i with no reads → RX_OVR=1, int_o=1, 16 bytes retained and the 17th lost. W1C clears RX_OVR.
5. Frame error and false start: drive stop bit=0 → FRM_ERR=1, RX_NE=0. Drive a 1-clock low glitch → no byte received, no error.
6. TX overflow and mid-frame reset: TX_EN=0, write 17 bytes → TX_FULL=1, TX_OVF=1. Enable TX, then assert reset mid-DATA → stx_pad_o=1 immediately, TX_IDLE=1.

Source files
------------

// File: rtl/wb_uart_lite.sv
// wb_uart_lite: 8-bit Wishbone-slave UART with TX/RX FIFOs, programmable bit divisor and loopback.
// TX line, bus read data, acknowledge and interrupt are all registered.

module wb_uart_lite_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == {1'b1, {AW{1'b0}}});
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end
endmodule

module wb_uart_lite #(
    parameter int          FIFO_DEPTH = 16,
    parameter int          DATA_BITS  = 8,
    parameter int          STOP_BITS  = 1,
    parameter logic [15:0] DIV_RESET  = 16'd867
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [2:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    input  logic       wb_we_i,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    output logic       wb_ack_o,
    output logic       stx_pad_o,
    input  logic       srx_pad_i,
    output logic       int_o
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic                 ack_q, ack_d, int_q, int_d;
    logic [7:0]           dat_q, dat_d, rd_mux, status;
    logic [15:0]          div_q, div_d, div_eff;
    logic [2:0]           ctrl_q, ctrl_d, clr;
    logic                 rx_ovr_q, rx_ovr_d, frm_err_q, frm_err_d, tx_ovf_q, tx_ovf_d;
    logic                 sync1_q, sync2_q, rx_prev_q, rx_in;
    logic                 req, bus_wr, bus_rd, data_wr;
    logic                 tx_push, tx_pop, tx_empty, tx_full, tx_ovf_set, tx_idle, tx_go;
    logic                 rx_push, rx_pop, rx_empty, rx_full, rx_ovr_set, frm_set;
    logic [DATA_BITS-1:0] tx_rdata, rx_rdata;

    state_t               tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [16:0]          tx_cnt_q, tx_cnt_d;
    logic [15:0]          rx_cnt_q, rx_cnt_d, tx_div_q, tx_div_d, rx_div_q, rx_div_d;
    logic [2:0]           tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic                 tx_q, tx_d;

    wb_uart_lite_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_tx_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .push_i(tx_push), .pop_i(tx_pop),
        .wdata_i(wb_dat_i[DATA_BITS-1:0]), .rdata_o(tx_rdata),
        .empty_o(tx_empty), .full_o(tx_full)
    );

    wb_uart_lite_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_rx_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .push_i(rx_push), .pop_i(rx_pop),
        .wdata_i(rx_sh_q), .rdata_o(rx_rdata),
        .empty_o(rx_empty), .full_o(rx_full)
    );

    assign req        = wb_cyc_i & wb_stb_i & ~ack_q;
    assign bus_wr     = req & wb_we_i;
    assign bus_rd     = req & ~wb_we_i;
    assign data_wr    = bus_wr & (wb_adr_i == 3'd0);
    assign tx_push    = data_wr & ~tx_full;
    assign tx_ovf_set = data_wr & tx_full;
    assign rx_pop     = bus_rd & (wb_adr_i == 3'd0);
    assign clr        = (bus_wr && wb_adr_i == 3'd1) ? wb_dat_i[5:3] : 3'b000;
    assign div_eff    = (div_q < 16'd3) ? 16'd3 : div_q;
    assign tx_idle    = tx_empty & (tx_state_q == S_IDLE);
    assign tx_go      = ctrl_q[0] & ~tx_empty;
    assign rx_in      = ctrl_q[2] ? tx_q : sync2_q;
    assign status     = {2'b00, tx_ovf_q, frm_err_q, rx_ovr_q, tx_idle, tx_full, ~rx_empty};

    always_comb begin
        div_d  = div_q;
        ctrl_d = ctrl_q;
        if (bus_wr && wb_adr_i == 3'd2) div_d[7:0]  = wb_dat_i;
        if (bus_wr && wb_adr_i == 3'd3) div_d[15:8] = wb_dat_i;
        if (bus_wr && wb_adr_i == 3'd4) ctrl_d      = wb_dat_i[2:0];
        rx_ovr_d  = rx_ovr_set | (rx_ovr_q & ~clr[0]);
        frm_err_d = frm_set | (frm_err_q & ~clr[1]);
        tx_ovf_d  = tx_ovf_set | (tx_ovf_q & ~clr[2]);
        case (wb_adr_i)
            3'd0:    rd_mux = rx_empty ? 8'h00 : 8'(rx_rdata);
            3'd1:    rd_mux = status;
            3'd2:    rd_mux = div_q[7:0];
            3'd3:    rd_mux = div_q[15:8];
            3'd4:    rd_mux = {5'b00000, ctrl_q};
            default: rd_mux = 8'h00;
        endcase
        dat_d = bus_rd ? rd_mux : 8'h00;
        ack_d = req;
        int_d = ~rx_empty | rx_ovr_q | frm_err_q | tx_ovf_q;
    end

    // TX: a frame start pops the FIFO and freezes the divisor for the whole frame.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_div_d   = tx_div_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (tx_go) begin
                    tx_pop     = 1'b1;
                    tx_sh_d    = tx_rdata;
                    tx_div_d   = div_eff;
                    tx_cnt_d   = {1'b0, div_eff};
                    tx_d       = 1'b0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = S_DATA;
                    tx_d       = tx_sh_q[0];
                    tx_bit_d   = 3'd0;
                    tx_cnt_d   = {1'b0, tx_div_q};
                end else begin
                    tx_cnt_d = tx_cnt_q - 17'd1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == '0) begin
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = S_STOP;
                        tx_d       = 1'b1;
                        tx_cnt_d   = (STOP_BITS == 2) ? {tx_div_q, 1'b1} : {1'b0, tx_div_q};
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_sh_d  = tx_sh_q >> 1;
                        tx_d     = tx_sh_q[1];
                        tx_cnt_d = {1'b0, tx_div_q};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 17'd1;
                end
            end
            default: begin
                if (tx_cnt_q == '0) begin
                    if (tx_go) begin
                        tx_pop     = 1'b1;
                        tx_sh_d    = tx_rdata;
                        tx_div_d   = div_eff;
                        tx_cnt_d   = {1'b0, div_eff};
                        tx_d       = 1'b0;
                        tx_state_d = S_START;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 17'd1;
                end
            end
        endcase
    end

    // RX: start sample lands near mid-bit, later samples one bit period apart.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_div_d   = rx_div_q;
        rx_push    = 1'b0;
        rx_ovr_set = 1'b0;
        frm_set    = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (ctrl_q[1] && rx_prev_q && !rx_in) begin
                    rx_div_d   = div_eff;
                    rx_cnt_d   = (div_eff >> 1) - 16'd1;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = rx_in ? S_IDLE : S_DATA;
                    rx_bit_d   = 3'd0;
                    rx_cnt_d   = rx_div_q;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_sh_d    = {rx_in, rx_sh_q[DATA_BITS-1:1]};
                    rx_cnt_d   = rx_div_q;
                    rx_bit_d   = rx_bit_q + 3'd1;
                    rx_state_d = (rx_bit_q == LAST_BIT) ? S_STOP : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = S_IDLE;
                    frm_set    = ~rx_in;
                    rx_ovr_set = rx_in & rx_full;
                    rx_push    = rx_in & ~rx_full;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= 8'h00;
            int_q      <= 1'b0;
            div_q      <= DIV_RESET;
            ctrl_q     <= 3'b011;
            rx_ovr_q   <= 1'b0;
            frm_err_q  <= 1'b0;
            tx_ovf_q   <= 1'b0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_div_q   <= '0;
            tx_q       <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_div_q   <= '0;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            int_q      <= int_d;
            div_q      <= div_d;
            ctrl_q     <= ctrl_d;
            rx_ovr_q   <= rx_ovr_d;
            frm_err_q  <= frm_err_d;
            tx_ovf_q   <= tx_ovf_d;
            sync1_q    <= srx_pad_i;
            sync2_q    <= sync1_q;
            rx_prev_q  <= rx_in;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_div_q   <= tx_div_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_div_q   <= rx_div_d;
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
    assign int_o     = int_q;
    assign stx_pad_o = tx_q;
endmodule

// File: tb/tb_wb_uart_lite.sv
// Self-checking bench for wb_uart_lite: bus reads and serial TX frames are scored against
// expected-value queues filled when the stimulus is driven.

module tb_wb_uart_lite;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] adr = '0;
    logic [7:0] dat_i = '0;
    logic [7:0] dat_o;
    logic       we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic       ack, stx, int_o;
    logic       srx = 1'b1;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc_cnt = 0;
    logic       mon_en = 1'b1;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int         tx_starts[$];

    wb_uart_lite dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i),
        .wb_dat_o(dat_o), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_ack_o(ack), .stx_pad_o(stx), .srx_pad_i(srx), .int_o(int_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic [2:0] a, input logic w, input logic [7:0] d,
                           output logic [7:0] q);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        adr = a; we = w; dat_i = d; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(posedge clk); #1;
            seen = ack;
        end
        q = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("wb_ack", seen, 1'b1);
        $display("wb %s adr=%0d data=0x%02h", w ? "wr" : "rd", a, w ? d : q);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] q;
        wb_xfer(a, 1'b1, d, q);
    endtask

    task automatic rd_expect(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] q;
        wb_xfer(a, 1'b0, 8'h00, q);
        check(tag, q, exp);
    endtask

    task automatic rx_pop_check(input string tag);
        logic [7:0] q, e;
        wb_xfer(3'd0, 1'b0, 8'h00, q);
        check({tag, "_sb_nonempty"}, rx_exp.size() > 0, 1'b1);
        e = (rx_exp.size() > 0) ? rx_exp.pop_front() : 8'h00;
        check(tag, q, e);
    endtask

    // Drives one 8N1 frame on srx at 4 clocks per bit (divisor 3).
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            srx = fr[i];
            repeat (4) @(posedge clk);
            #1;
        end
        srx = 1'b1;
        repeat (3) @(posedge clk);
        $display("rx frame driven 0x%02h stop=%0b", b, stop);
    endtask

    // Serial TX monitor, assumes 4 clocks per bit while enabled.
    initial begin
        logic [7:0] b, e;
        logic st, sp;
        forever begin
            @(posedge clk); #1;
            if (mon_en && !rst && stx === 1'b0) begin
                tx_starts.push_back(cyc_cnt);
                repeat (2) @(posedge clk);
                #1 st = stx;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(posedge clk);
                    #1 b[i] = stx;
                end
                repeat (4) @(posedge clk);
                #1 sp = stx;
                check("tx_sb_nonempty", tx_exp.size() > 0, 1'b1);
                e = (tx_exp.size() > 0) ? tx_exp.pop_front() : 8'h00;
                check("tx_frame", {sp, b, st}, {1'b1, e, 1'b0});
                $display("tx frame 0x%02h", b);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] seen, want;
        logic [9:0]  fr;
        logic        fell;

        // Reset defaults
        repeat (3) @(posedge clk);
        #1;
        check("rst_stx", stx, 1'b1);
        check("rst_ack", ack, 1'b0);
        check("rst_dat", dat_o, 8'h00);
        check("rst_int", int_o, 1'b0);
        @(negedge clk) rst = 1'b0;
        rd_expect("rst_status", 3'd1, 8'h04);
        rd_expect("rst_ctrl", 3'd4, 8'h03);
        rd_expect("rst_div_lo", 3'd2, 8'h63);
        rd_expect("rst_div_hi", 3'd3, 8'h03);
        rd_expect("unmapped_rd", 3'd6, 8'h00);

        // Single TX frame, cycle-exact
        wr(3'd2, 8'h03);
        wr(3'd3, 8'h00);
        tx_exp.push_back(8'hA5);
        wr(3'd0, 8'hA5);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            seen[k] = stx;
            want[k] = fr[k / 4];
        end
        check("tx_a5_waveform", seen, want);
        @(posedge clk); #1;
        check("tx_a5_idle_line", stx, 1'b1);
        rd_expect("tx_a5_status", 3'd1, 8'h04);

        // Loopback burst
        tx_starts.delete();
        wr(3'd4, 8'h07);
        for (int i = 1; i <= 16; i++) begin
            tx_exp.push_back(8'(i));
            rx_exp.push_back(8'(i));
            wr(3'd0, 8'(i));
        end
        repeat (700) @(posedge clk);
        rd_expect("loop_status", 3'd1, 8'h05);
        check("loop_frames", tx_starts.size(), 16);
        if (tx_starts.size() == 16)
            check("loop_no_gap", tx_starts[15] - tx_starts[0], 15 * 40);
        for (int i = 0; i < 16; i++) rx_pop_check("loop_rx");
        rd_expect("loop_status_end", 3'd1, 8'h04);

        // RX overrun
        wr(3'd4, 8'h03);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) rx_exp.push_back(8'h30 + 8'(i));
            send_rx(8'h30 + 8'(i), 1'b1);
        end
        rd_expect("ovr_status", 3'd1, 8'h0D);
        check("ovr_int", int_o, 1'b1);
        wr(3'd1, 8'h08);
        rd_expect("ovr_w1c", 3'd1, 8'h05);
        for (int i = 0; i < 16; i++) rx_pop_check("ovr_rx");
        rd_expect("rx_empty_read", 3'd0, 8'h00);
        rd_expect("ovr_status_end", 3'd1, 8'h04);
        check("ovr_int_clear", int_o, 1'b0);

        // Frame error and false start
        send_rx(8'h55, 1'b0);
        rd_expect("frm_status", 3'd1, 8'h14);
        check("frm_int", int_o, 1'b1);
        wr(3'd1, 8'h10);
        rd_expect("frm_w1c", 3'd1, 8'h04);
        @(posedge clk); #1 srx = 1'b0;
        @(posedge clk); #1 srx = 1'b1;
        repeat (20) @(posedge clk);
        rd_expect("glitch_status", 3'd1, 8'h04);
        check("glitch_int", int_o, 1'b0);

        // TX overflow and mid-frame reset
        mon_en = 1'b0;
        wr(3'd4, 8'h00);
        for (int i = 0; i < 17; i++) wr(3'd0, 8'hC0 + 8'(i));
        rd_expect("ovf_status", 3'd1, 8'h22);
        check("ovf_int", int_o, 1'b1);
        wr(3'd4, 8'h01);
        fell = 1'b0;
        for (int i = 0; i < 20 && !fell; i++) begin
            @(posedge clk); #1;
            fell = ~stx;
        end
        check("ovf_tx_start", fell, 1'b1);
        repeat (8) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midreset_stx", stx, 1'b1);
        check("midreset_int", int_o, 1'b0);
        check("midreset_ack", ack, 1'b0);
        @(negedge clk) rst = 1'b0;
        rd_expect("midreset_status", 3'd1, 8'h04);
        rd_expect("midreset_div_lo", 3'd2, 8'h63);
        rd_expect("midreset_ctrl", 3'd4, 8'h03);
        check("midreset_line", stx, 1'b1);

        check("tx_sb_drained", tx_exp.size(), 0);
        check("rx_sb_drained", rx_exp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
